// File: rtl/x8_approx_seq_mul_if.sv
// Handshake/bus bundle for x8_approx_seq_mul.
//   start  : request, operands sampled when start=1 and busy=0
//   a, b   : 8-bit unsigned multiplicand / multiplier
//   busy   : operation in progress
//   done   : single-cycle pulse, result valid and new
//   result : 16-bit product, held until next accepted start
// master = requester (core-side multiply control), slave = multiplier.
interface x8_approx_seq_mul_if;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] result;

   modport master (output start, a, b, input busy, done, result);
   modport slave  (input start, a, b, output busy, done, result);
endinterface

// File: rtl/x8_approx_seq_mul.sv
// x8_approx_add: 8-bit adder whose N4 low bits are approximate cells.
//   Approximate cell i: sum[i] = a[i] | b[i] (bit 0 also ORs in cin).
//   The exact upper part receives carry a[N4-1] & b[N4-1].
//   N4=0 is a plain exact ripple adder.
//   Ports: a, b (8), cin (1) -> sum (8), cout (1).
//
// x8_approx_seq_mul: iterative 8x8 unsigned shift-and-add multiplier.
//   Each of the 8 partial-product accumulations goes through one x8_approx_add.
//   Ports: clk, rst (sync, active-high), mif (slave modport of x8_approx_seq_mul_if).
//   Latency: start sampled at end of cycle 0, busy cycles 1..8, done/result in cycle 9.
module x8_approx_add #(
   parameter int N4 = 0
) (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);
   generate
      if (N4 == 0) begin : g_exact
         assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'h00, cin};
      end else if (N4 >= 8) begin : g_all_approx
         assign sum  = (a | b) | {7'h00, cin};
         assign cout = a[7] & b[7];
      end else begin : g_mixed
         localparam int HW = 8 - N4;
         logic carry;
         assign carry          = a[N4-1] & b[N4-1];
         assign sum[N4-1:0]    = (a[N4-1:0] | b[N4-1:0]) | {{(N4-1){1'b0}}, cin};
         assign {cout, sum[7:N4]} = {1'b0, a[7:N4]} + {1'b0, b[7:N4]} + {{HW{1'b0}}, carry};
      end
   endgenerate
endmodule

module x8_approx_seq_mul #(
   parameter int N4 = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   x8_approx_seq_mul_if.slave   mif
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [7:0]  mcand_q, mcand_d;
   logic [7:0]  acc_hi_q, acc_hi_d;
   logic [7:0]  acc_lo_q, acc_lo_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] result_q, result_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic [7:0]  add_b;
   logic [7:0]  add_sum;
   logic        add_cout;
   logic [15:0] step_val;
   logic        accept;

   // Zero partial products still go through the adder so the approximation
   // error model is the same on every step.
   assign add_b = acc_lo_q[0] ? mcand_q : 8'h00;

   x8_approx_add #(.N4(N4)) u_add (
      .a    (acc_hi_q),
      .b    (add_b),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Carry-out becomes the 9th bit shifted into the accumulator.
   assign step_val = {add_cout, add_sum, acc_lo_q[7:1]};
   assign accept   = mif.start && (state_q != S_RUN);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         mcand_q  <= 8'h00;
         acc_hi_q <= 8'h00;
         acc_lo_q <= 8'h00;
         cnt_q    <= 4'd0;
         result_q <= 16'h0000;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic. cnt_q==7 is the edge on which the 8th step lands,
   // so cnt reaches 8 as the state enters DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (mif.start) state_d = S_RUN;
         S_RUN:   if (cnt_q == 4'd7) state_d = S_DONE;
         S_DONE:  state_d = mif.start ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_comb begin
      mcand_d  = mcand_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      if (accept) begin
         mcand_d  = mif.a;
         acc_lo_d = mif.b;
         acc_hi_d = 8'h00;
         cnt_d    = 4'd0;
      end else if (state_q == S_RUN) begin
         {acc_hi_d, acc_lo_d} = step_val;
         cnt_d                = cnt_q + 4'd1;
         if (cnt_q == 4'd7) result_d = step_val;
      end
      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   assign mif.busy   = busy_q;
   assign mif.done   = done_q;
   assign mif.result = result_q;
endmodule

// File: tb/tb_x8_approx_seq_mul.sv
module tb_x8_approx_seq_mul;
   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   x8_approx_seq_mul_if if0 ();
   x8_approx_seq_mul_if if4 ();
   x8_approx_seq_mul_if if8 ();

   x8_approx_seq_mul #(.N4(0)) dut0 (.clk(clk), .rst(rst), .mif(if0));
   x8_approx_seq_mul #(.N4(4)) dut4 (.clk(clk), .rst(rst), .mif(if4));
   x8_approx_seq_mul #(.N4(8)) dut8 (.clk(clk), .rst(rst), .mif(if8));

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] e;
   } vec_t;

   typedef struct {
      logic [15:0] e0;
      logic [15:0] e4;
      logic [15:0] e8;
   } exp_t;

   exp_t sb[$];

   // Reference adder, bit-serial: OR cells below n4, ripple above.
   function automatic logic [8:0] m_add(input logic [7:0] x, input logic [7:0] y,
                                        input logic ci, input int n4);
      logic [8:0] r;
      logic       c;
      r = '0;
      c = ci;
      for (int i = 0; i < 8; i++) begin
         if (i < n4) begin
            r[i] = x[i] | y[i] | ((i == 0) ? ci : 1'b0);
            if (i == n4 - 1) c = x[i] & y[i];
         end else begin
            r[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
         end
      end
      r[8] = c;
      return r;
   endfunction

   function automatic logic [15:0] m_mul(input logic [7:0] x, input logic [7:0] y, input int n4);
      logic [7:0] hi, lo;
      logic [8:0] s;
      hi = 8'h00;
      lo = y;
      for (int k = 0; k < 8; k++) begin
         s = m_add(hi, lo[0] ? x : 8'h00, 1'b0, n4);
         {hi, lo} = {s, lo[7:1]};
      end
      return {hi, lo};
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic s, input logic [7:0] x, input logic [7:0] y);
      if0.start = s; if0.a = x; if0.b = y;
      if4.start = s; if4.a = x; if4.b = y;
      if8.start = s; if8.a = x; if8.b = y;
   endtask

   task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e0);
      exp_t e;
      drv(1'b1, x, y);
      e.e0 = e0;
      e.e4 = m_mul(x, y, 4);
      e.e8 = m_mul(x, y, 8);
      sb.push_back(e);
   endtask

   task automatic retire(input string nm);
      exp_t e;
      if (sb.size() == 0) begin
         chk({nm, "_sb_empty"}, 16'd1, 16'd0);
         return;
      end
      e = sb.pop_front();
      chk({nm, "_res_n0"}, if0.result, e.e0);
      chk({nm, "_res_n4"}, if4.result, e.e4);
      chk({nm, "_res_n8"}, if8.result, e.e8);
   endtask

   task automatic chk_flags(input string nm, input logic bsy, input logic dn);
      chk({nm, "_busy"}, {13'd0, if0.busy, if4.busy, if8.busy}, {13'd0, bsy, bsy, bsy});
      chk({nm, "_done"}, {13'd0, if0.done, if4.done, if8.done}, {13'd0, dn, dn, dn});
   endtask

   // Called in cycle 0 right after issue(); returns in the done cycle (bounded).
   task automatic wait_done(output int cyc);
      step();
      drv(1'b0, if0.a, if0.b);
      cyc = 1;
      while (!if0.done && cyc < 20) begin
         step();
         cyc++;
      end
   endtask

   always @(negedge clk) begin
      if ((if0.busy && if0.done) || (if4.busy && if4.done) || (if8.busy && if8.done)) begin
         n_tests++;
         n_fail++;
         $display("FAIL busy_done_overlap: busy and done both 1 at %0t", $time);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      int   cyc;
      logic [7:0] ra, rb;
      bit   saw;

      vecs[0] = '{8'd13,  8'd11,  16'h008F};
      vecs[1] = '{8'd255, 8'd255, 16'hFE01};
      vecs[2] = '{8'd0,   8'd200, 16'h0000};
      vecs[3] = '{8'd200, 8'd0,   16'h0000};
      vecs[4] = '{8'd10,  8'd10,  16'd100};
      vecs[5] = '{8'd1,   8'd1,   16'd1};
      vecs[6] = '{8'd128, 8'd2,   16'd256};
      vecs[7] = '{8'd255, 8'd1,   16'd255};

      // Reset state
      rst = 1'b1;
      drv(1'b0, 8'h00, 8'h00);
      step(); step(); step();
      chk_flags("reset", 1'b0, 1'b0);
      chk("reset_result", if0.result | if4.result | if8.result, 16'h0000);
      rst = 1'b0;
      step();
      chk_flags("post_reset", 1'b0, 1'b0);

      // Table vectors, cycle-exact handshake check
      foreach (vecs[i]) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].e);
         step();
         drv(1'b0, 8'h00, 8'h00);
         for (int c = 1; c <= 8; c++) begin
            chk_flags($sformatf("vec%0d_c%0d", i, c), 1'b1, 1'b0);
            step();
         end
         chk_flags($sformatf("vec%0d_c9", i), 1'b0, 1'b1);
         retire($sformatf("vec%0d", i));
         step();
         chk_flags($sformatf("vec%0d_c10", i), 1'b0, 1'b0);
         chk($sformatf("vec%0d_hold", i), if0.result, vecs[i].e);
      end

      // start held high 20 cycles, operands wiggled while busy
      issue(8'd3, 8'd5, 16'd15);
      for (int c = 1; c <= 19; c++) begin
         step();
         if (c == 2 || c == 12) drv(1'b1, 8'd100, 8'd100);
         if (c == 8 || c == 17) drv(1'b1, 8'd3, 8'd5);
         if (c == 9 || c == 18) begin
            chk_flags($sformatf("held_c%0d", c), 1'b0, 1'b1);
            retire($sformatf("held_c%0d", c));
            chk($sformatf("held_c%0d_exact", c), if0.result, 16'd15);
            issue(8'd3, 8'd5, 16'd15);
         end
         if (c == 10 || c == 19) chk_flags($sformatf("held_c%0d", c), 1'b1, 1'b0);
      end
      step();
      drv(1'b0, 8'd0, 8'd0);
      cyc = 2;
      while (!if0.done && cyc < 20) begin
         step();
         cyc++;
      end
      chk("held_third_latency", 16'(cyc), 16'd9);
      retire("held_third");

      // Reset in cycle 4 of RUN
      issue(8'd200, 8'd200, 16'd40000);
      step();
      drv(1'b0, 8'd0, 8'd0);
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      void'(sb.pop_back());
      chk_flags("abort", 1'b0, 1'b0);
      chk("abort_result", if0.result | if4.result | if8.result, 16'h0000);
      saw = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (if0.done || if4.done || if8.done) saw = 1'b1;
         step();
      end
      chk("abort_no_done", {15'd0, saw}, 16'd0);
      issue(8'd7, 8'd9, 16'd63);
      wait_done(cyc);
      chk("after_abort_latency", 16'(cyc), 16'd9);
      retire("after_abort");

      // Back-to-back: new start in the done cycle, old product held
      step();
      issue(8'd10, 8'd10, 16'd100);
      wait_done(cyc);
      chk("b2b_first_latency", 16'(cyc), 16'd9);
      retire("b2b_first");
      issue(8'd2, 8'd3, 16'd6);
      step();
      drv(1'b0, 8'd0, 8'd0);
      for (int c = 10; c <= 17; c++) begin
         chk($sformatf("b2b_hold_c%0d", c), if0.result, 16'd100);
         chk_flags($sformatf("b2b_c%0d", c), 1'b1, 1'b0);
         step();
      end
      chk_flags("b2b_c18", 1'b0, 1'b1);
      retire("b2b_second");
      step();

      // Random pairs: N4=0 exact, N4=4/8 against the step-wise model
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         issue(ra, rb, 16'({8'h00, ra} * {8'h00, rb}));
         wait_done(cyc);
         chk($sformatf("rnd%0d_latency", i), 16'(cyc), 16'd9);
         retire($sformatf("rnd%0d_a%0d_b%0d", i, ra, rb));
         if ((i % 3) == 0) step();
      end

      chk("sb_drained", 16'(sb.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
